// File: rtl/morse_player.sv
// Plays one 5-symbol Morse character on the keyer line: marks of 1 or 3 units,
// 1-unit gaps between symbols, and a 3-unit gap after the last symbol.
module morse_player #(
    parameter int unsigned UNIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] morse,
    input  logic       ready,
    output logic       key,
    output logic       busy,
    output logic       done
);

    // Prescaler must reach 3*UNIT_CYCLES-1 without wrapping.
    localparam int unsigned CW = $clog2(3 * UNIT_CYCLES);
    localparam logic [CW-1:0] ONE_LAST   = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] THREE_LAST = CW'(3 * UNIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        GAP,
        CHARGAP
    } state_t;

    state_t        state, state_next;
    logic [4:0]    shreg, shreg_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    idx, idx_next;
    logic          done_next;
    logic [CW-1:0] mark_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            idx   <= '0;
            key   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state <= state_next;
            shreg <= shreg_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
            key   <= (state_next == MARK);
            busy  <= (state_next != IDLE);
            done  <= done_next;
        end
    end

    // The current symbol always sits in shreg[0]; the register shifts right after each mark.
    assign mark_last = shreg[0] ? ONE_LAST : THREE_LAST;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latches are inferred.
        state_next = state;
        shreg_next = shreg;
        cnt_next   = cnt;
        idx_next   = idx;
        done_next  = 1'b0;

        unique case (state)
            IDLE: begin
                if (ready) begin
                    shreg_next = morse;
                    idx_next   = 3'd0;
                    cnt_next   = '0;
                    state_next = MARK;
                end
            end
            MARK: begin
                if (cnt == mark_last) begin
                    cnt_next   = '0;
                    shreg_next = {1'b0, shreg[4:1]};
                    state_next = (idx == 3'd4) ? CHARGAP : GAP;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == ONE_LAST) begin
                    cnt_next   = '0;
                    idx_next   = idx + 3'd1;
                    state_next = MARK;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            CHARGAP: begin
                if (cnt == THREE_LAST) begin
                    cnt_next   = '0;
                    idx_next   = 3'd0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
